// File: rtl/fmap_row_packer_pkg.sv
// Shared constants and FSM state type for the feature-map buffer feeders.
package fmap_pkg;
    localparam int PIX_W        = 32;
    localparam int PIX_PER_WORD = 8;
    localparam int IMG_W        = 227;
    localparam int ROW_PIX      = 232;
    localparam int ROW_WORDS    = ROW_PIX / PIX_PER_WORD;
    localparam int MAX_ROWS     = 17;
    localparam int ADDR_W       = 9;
    localparam int BUF_DEPTH    = 512;
    localparam int WORD_W       = PIX_W * PIX_PER_WORD;
    localparam int LANE_W       = 3;
    localparam int PIX_CNT_W    = 8;
    localparam int ROW_CNT_W    = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_t;

    // True when a job of 'rows' padded rows starting at 'base' fits inside the buffer.
    function automatic logic job_fits(input logic [ADDR_W-1:0] base,
                                      input logic [ROW_CNT_W-1:0] rows);
        logic [11:0] end_addr;
        end_addr = 12'(base) + 12'(rows) * 12'(ROW_WORDS);
        return (rows != '0) && (int'(rows) <= MAX_ROWS) && (end_addr <= 12'(BUF_DEPTH));
    endfunction
endpackage

// File: rtl/fmap_row_packer_if.sv
// Pixel stream in, buffer write port out; master is the packer side.
interface fmap_row_packer_if;
    import fmap_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [PIX_W-1:0]  s_pixel;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [WORD_W-1:0] dina;

    modport master (input s_valid, s_pixel, output s_ready, wea, addra, dina);
    modport slave  (output s_valid, s_pixel, input s_ready, wea, addra, dina);
endinterface

// File: rtl/fmap_row_packer_pix.sv
// Lane accumulator: gathers pixels into a 256-bit word, emits it on lane 7 or flush.
module pix_word_packer
    import fmap_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic [PIX_W-1:0]  i_pixel,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);
    logic [PIX_W-1:0]  r_lane_data [PIX_PER_WORD];
    logic [LANE_W-1:0] r_lane;
    logic              r_word_valid;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word;
    logic              w_complete;

    assign w_complete = i_load && ((r_lane == LANE_W'(PIX_PER_WORD - 1)) || i_flush);

    generate
        for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
            // The pixel arriving this cycle is merged so a completed word leaves without a bubble.
            assign w_word[gi*PIX_W +: PIX_W] =
                (i_load && r_lane == LANE_W'(gi)) ? i_pixel : r_lane_data[gi];

            always_ff @(posedge clk) begin
                if (srst || w_complete) begin
                    r_lane_data[gi] <= '0;
                end else if (i_load && r_lane == LANE_W'(gi)) begin
                    r_lane_data[gi] <= i_pixel;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            r_lane       <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_valid <= w_complete;
            if (w_complete) begin
                r_word <= w_word;
                r_lane <= '0;
            end else if (i_load) begin
                r_lane <= r_lane + 1'b1;
            end
        end
    end

    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;
endmodule

// File: rtl/fmap_row_packer.sv
// Packs a row-major pixel stream into zero-padded 29-word rows of the feature-map buffer.
module fmap_row_packer
    import fmap_pkg::*;
(
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ROW_CNT_W-1:0] num_rows,
    fmap_row_packer_if.master    pbus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    fsm_state_t           r_state;
    fsm_state_t           w_state_next;
    logic [ROW_CNT_W-1:0] r_num_rows;
    logic [ROW_CNT_W-1:0] r_row_cnt;
    logic [PIX_CNT_W-1:0] r_pix_cnt;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [ADDR_W-1:0]    r_addra;
    logic                 r_done;
    logic                 r_err;

    logic w_run, w_accept, w_last_pix, w_last_row, w_job_end, w_word_done;
    logic w_start_req, w_start_ok, w_wea;
    logic [WORD_W-1:0] w_word;

    assign w_run       = (r_state == ST_RUN);
    assign w_accept    = w_run && pbus.s_valid;
    assign w_last_pix  = (r_pix_cnt == PIX_CNT_W'(IMG_W - 1));
    assign w_last_row  = (r_row_cnt == r_num_rows - 1'b1);
    assign w_job_end   = w_accept && w_last_pix && w_last_row;
    assign w_word_done = w_accept && ((r_pix_cnt[LANE_W-1:0] == '1) || w_last_pix);
    // The done cycle still reports busy, so a start landing there is ignored.
    assign w_start_req = start && (r_state == ST_IDLE) && !r_done;
    assign w_start_ok  = w_start_req && job_fits(base_addr, num_rows);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_state_next = ST_RUN;
            ST_RUN:  if (w_job_end)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_state    <= ST_IDLE;
            r_num_rows <= '0;
            r_row_cnt  <= '0;
            r_pix_cnt  <= '0;
            r_wr_addr  <= '0;
            r_addra    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_job_end;
            r_err   <= w_start_req && !w_start_ok;
            if (w_start_ok) begin
                r_num_rows <= num_rows;
                r_wr_addr  <= base_addr;
                r_row_cnt  <= '0;
                r_pix_cnt  <= '0;
            end else if (w_accept) begin
                r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
                if (w_last_pix) r_row_cnt <= r_row_cnt + 1'b1;
            end
            // Rows are contiguous, so a running address replaces base + row*29 + word.
            if (w_word_done) begin
                r_addra   <= r_wr_addr;
                r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    pix_word_packer u_packer (
        .clk          (clka),
        .srst         (rsta),
        .i_load       (w_accept),
        .i_flush      (w_last_pix),
        .i_pixel      (pbus.s_pixel),
        .o_word_valid (w_wea),
        .o_word       (w_word)
    );

    assign pbus.s_ready = w_run;
    assign pbus.wea     = w_wea;
    assign pbus.addra   = r_addra;
    assign pbus.dina    = w_word;
    assign busy         = w_run || r_done;
    assign done         = r_done;
    assign err          = r_err;
endmodule

// File: tb/tb_fmap_row_packer.sv
// Randomized bench: expected buffer writes are computed from whole-job pixel arrays.
module tb_fmap_row_packer;
    import fmap_pkg::*;

    logic                 clka = 1'b0;
    logic                 rsta;
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic [ROW_CNT_W-1:0] num_rows;
    logic                 busy, done, err;

    fmap_row_packer_if pbus ();

    fmap_row_packer dut (
        .clka      (clka),
        .rsta      (rsta),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .pbus      (pbus.master),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clka = ~clka;

    int n_cmp = 0;
    int n_bad = 0;

    logic [PIX_W-1:0]  pix_mem [MAX_ROWS*IMG_W];
    logic [ADDR_W-1:0] exp_addr [$];
    logic [WORD_W-1:0] exp_data [$];
    logic [ADDR_W-1:0] got_addr [$];
    logic [WORD_W-1:0] got_data [$];
    bit                got_done [$];
    int                n_done_pulses;
    int                n_err_pulses;
    int                n_orphan_done;

    task automatic check(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clka) begin
        if (pbus.wea) begin
            got_addr.push_back(pbus.addra);
            got_data.push_back(pbus.dina);
            got_done.push_back(done);
        end
        if (done) n_done_pulses++;
        if (done && !pbus.wea) n_orphan_done++;
        if (err) n_err_pulses++;
    end

    task automatic clear_capture();
        got_addr.delete();
        got_data.delete();
        got_done.delete();
        n_done_pulses = 0;
        n_err_pulses  = 0;
        n_orphan_done = 0;
    endtask

    // Reference: word w of row r holds columns 8w..8w+7, zero beyond column 226.
    task automatic build_expected(input int base, input int rows);
        logic [WORD_W-1:0] word;
        exp_addr.delete();
        exp_data.delete();
        for (int r = 0; r < rows; r++) begin
            for (int w = 0; w < ROW_WORDS; w++) begin
                word = '0;
                for (int k = 0; k < PIX_PER_WORD; k++) begin
                    int col;
                    col = w * PIX_PER_WORD + k;
                    if (col < IMG_W) word[k*PIX_W +: PIX_W] = pix_mem[r*IMG_W + col];
                end
                exp_addr.push_back(ADDR_W'((base + r*ROW_WORDS + w) % BUF_DEPTH));
                exp_data.push_back(word);
            end
        end
    endtask

    task automatic do_start(input int base, input int rows);
        @(negedge clka);
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        num_rows  = ROW_CNT_W'(rows);
        @(negedge clka);
        start = 1'b0;
    endtask

    task automatic drive_pixels(input int total, input int idle_pct, output int ready_low);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        ready_low = 0;
        while (idx < total && cyc < 20000) begin
            @(negedge clka);
            if (!pbus.s_ready) ready_low++;
            if ($urandom_range(99) < idle_pct) begin
                pbus.s_valid = 1'b0;
            end else begin
                pbus.s_valid = 1'b1;
                pbus.s_pixel = pix_mem[idx];
            end
            if (pbus.s_valid && pbus.s_ready) idx++;
            cyc++;
        end
        @(negedge clka);
        pbus.s_valid = 1'b0;
        if (idx != total) check("drive_timeout", WORD_W'(idx), WORD_W'(total));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clka);
            t++;
        end
        if (t >= 2000) check("busy_timeout", WORD_W'(busy), WORD_W'(0));
        repeat (4) @(negedge clka);
    endtask

    task automatic compare_job(input string tag);
        int n;
        check({tag, "_nwrites"}, WORD_W'(got_addr.size()), WORD_W'(exp_addr.size()));
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), WORD_W'(got_addr[i]), WORD_W'(exp_addr[i]));
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        end
        if (n > 0) check({tag, "_done_last"}, WORD_W'(got_done[n-1]), WORD_W'(1));
        check({tag, "_done_count"}, WORD_W'(n_done_pulses), WORD_W'(1));
        check({tag, "_done_orphan"}, WORD_W'(n_orphan_done), WORD_W'(0));
        check({tag, "_err_count"}, WORD_W'(n_err_pulses), WORD_W'(0));
        $display("job %s: %0d writes captured, %0d expected", tag, got_addr.size(), exp_addr.size());
    endtask

    task automatic run_job(input string tag, input int base, input int rows, input int idle_pct,
                           input bit expect_no_stall);
        int ready_low;
        clear_capture();
        build_expected(base, rows);
        do_start(base, rows);
        check({tag, "_busy_after_start"}, WORD_W'(busy), WORD_W'(1));
        drive_pixels(rows * IMG_W, idle_pct, ready_low);
        wait_idle();
        compare_job(tag);
        if (expect_no_stall) check({tag, "_ready_gaps"}, WORD_W'(ready_low), WORD_W'(0));
    endtask

    task automatic try_reject(input string tag, input int base, input int rows);
        clear_capture();
        do_start(base, rows);
        check({tag, "_busy"}, WORD_W'(busy), WORD_W'(0));
        repeat (5) @(negedge clka);
        check({tag, "_err_pulses"}, WORD_W'(n_err_pulses), WORD_W'(1));
        check({tag, "_writes"}, WORD_W'(got_addr.size()), WORD_W'(0));
        $display("reject %s: base=%0d rows=%0d err_pulses=%0d", tag, base, rows, n_err_pulses);
    endtask

    initial begin
        int ready_low;
        rsta         = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_rows     = '0;
        pbus.s_valid = 1'b0;
        pbus.s_pixel = '0;
        repeat (3) @(negedge clka);
        rsta = 1'b0;
        @(negedge clka);
        check("rst_wea",     WORD_W'(pbus.wea),     WORD_W'(0));
        check("rst_addra",   WORD_W'(pbus.addra),   WORD_W'(0));
        check("rst_dina",    pbus.dina,             WORD_W'(0));
        check("rst_s_ready", WORD_W'(pbus.s_ready), WORD_W'(0));
        check("rst_busy",    WORD_W'(busy),         WORD_W'(0));
        check("rst_done",    WORD_W'(done),         WORD_W'(0));
        check("rst_err",     WORD_W'(err),          WORD_W'(0));

        // One row at full rate, pixels 1..227.
        for (int i = 0; i < IMG_W; i++) pix_mem[i] = PIX_W'(i + 1);
        run_job("row1", 0, 1, 0, 1'b1);

        // Full 17-row job, pixel = row*1000 + col.
        for (int r = 0; r < MAX_ROWS; r++)
            for (int c = 0; c < IMG_W; c++) pix_mem[r*IMG_W + c] = PIX_W'(r*1000 + c);
        run_job("full17", 0, MAX_ROWS, 0, 1'b1);
        if (got_addr.size() > 29) check("full17_addr29_lane0", WORD_W'(got_data[29][31:0]), WORD_W'(1000));

        try_reject("rows18", 0, 18);
        try_reject("rows0", 0, 0);
        try_reject("overflow", 480, 2);

        for (int i = 0; i < IMG_W; i++) pix_mem[i] = $urandom;
        run_job("ctrl483", 483, 1, 0, 1'b1);
        if (got_addr.size() > 0) check("ctrl483_last_addr", WORD_W'(got_addr[got_addr.size()-1]), WORD_W'(511));

        // Random valid gaps on a 3-row job.
        for (int i = 0; i < 3*IMG_W; i++) pix_mem[i] = $urandom;
        run_job("gaps", 100, 3, 40, 1'b0);

        // Reset after 100 pixels of row 0: only the 12 completed words may appear.
        for (int i = 0; i < IMG_W; i++) pix_mem[i] = $urandom;
        clear_capture();
        build_expected(0, 1);
        do_start(0, 1);
        drive_pixels(100, 0, ready_low);
        rsta = 1'b1;
        @(negedge clka);
        rsta = 1'b0;
        repeat (20) @(negedge clka);
        check("rst_mid_nwrites", WORD_W'(got_addr.size()), WORD_W'(12));
        for (int i = 0; i < got_addr.size() && i < 12; i++) begin
            check($sformatf("rst_mid_addr%0d", i), WORD_W'(got_addr[i]), WORD_W'(exp_addr[i]));
            check($sformatf("rst_mid_data%0d", i), got_data[i], exp_data[i]);
        end
        check("rst_mid_busy", WORD_W'(busy), WORD_W'(0));
        check("rst_mid_done", WORD_W'(n_done_pulses), WORD_W'(0));
        $display("reset mid-job: %0d writes before reset", got_addr.size());
        for (int i = 0; i < IMG_W; i++) pix_mem[i] = $urandom;
        run_job("after_rst", 5, 1, 10, 1'b0);

        // Second start mid-job must be ignored.
        for (int i = 0; i < 2*IMG_W; i++) pix_mem[i] = $urandom;
        clear_capture();
        build_expected(200, 2);
        do_start(200, 2);
        fork
            drive_pixels(2*IMG_W, 0, ready_low);
            begin
                repeat (150) @(negedge clka);
                start     = 1'b1;
                base_addr = 9'd7;
                num_rows  = 5'd3;
                @(negedge clka);
                start = 1'b0;
            end
        join
        wait_idle();
        compare_job("restart_ignored");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
